// File: rtl/mc_recon.sv
// mc_recon: buffers one MB_SIZE x MB_SIZE reference block, then adds signed residual rows to it.
// Define MC_SAT_EN to clip each lane to the pixel range and report clipping on sat_flag_o.
module mc_recon #(
  parameter int MB_SIZE     = 4,
  parameter int PIXEL_WIDTH = 8,
  parameter int RES_WIDTH   = 9
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           ref_valid_i,
  output logic                           ref_ready_o,
  input  logic [PIXEL_WIDTH*MB_SIZE-1:0] ref_frame_i,
  input  logic                           res_valid_i,
  output logic                           res_ready_o,
  input  logic [RES_WIDTH*MB_SIZE-1:0]   residual_i,
  output logic                           recon_valid_o,
  input  logic                           recon_ready_i,
  output logic [PIXEL_WIDTH*MB_SIZE-1:0] recon_o,
  output logic [3:0]                     row_count_o,
  output logic                           block_done_o,
  output logic                           sat_flag_o
);

  // state    | meaning
  // IDLE     | waiting for row 0 of the next reference block
  // LOAD_REF | storing reference rows 1..MB_SIZE-1
  // RECON    | adding residual rows to the buffered reference
  // DRAIN    | waiting for the last reconstructed row to leave

  localparam int         SW       = PIXEL_WIDTH + 2;
  localparam int         IW       = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
  localparam int         RW_BITS  = PIXEL_WIDTH * MB_SIZE;
  localparam logic [3:0] LAST_ROW = 4'(MB_SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD_REF, RECON, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [3:0]         row_cnt_q, row_cnt_d;
  logic               recon_valid_q, recon_valid_d;
  logic [RW_BITS-1:0] recon_q, recon_d;
  logic               block_done_q, block_done_d;
  logic [RW_BITS-1:0] ref_buf_q [MB_SIZE];
  logic [IW-1:0]      row_idx, wr_idx;
  logic               ref_hs, res_hs, out_hs, last_row;
  logic [RW_BITS-1:0] sum_row;
`ifdef MC_SAT_EN
  logic               clip_any;
  logic               sat_q, sat_d;
`endif

  assign ref_ready_o = (state_q == IDLE) || (state_q == LOAD_REF);
  assign res_ready_o = (state_q == RECON) && (!recon_valid_q || recon_ready_i);
  assign ref_hs      = ref_valid_i && ref_ready_o;
  assign res_hs      = res_valid_i && res_ready_o;
  assign out_hs      = recon_valid_q && recon_ready_i;
  assign last_row    = (row_cnt_q == LAST_ROW);
  assign row_idx     = row_cnt_q[IW-1:0];
  assign wr_idx      = (state_q == IDLE) ? '0 : row_idx;

  // Per-lane sum carries two extra bits so both underflow and overflow are visible.
  always_comb begin
    logic signed [SW-1:0]    sum;
    logic [PIXEL_WIDTH-1:0]  ref_px;
    sum_row = '0;
    sum     = '0;
    ref_px  = '0;
`ifdef MC_SAT_EN
    clip_any = 1'b0;
`endif
    for (int i = 0; i < MB_SIZE; i++) begin
      ref_px = ref_buf_q[row_idx][i*PIXEL_WIDTH +: PIXEL_WIDTH];
      sum    = $signed({2'b00, ref_px}) + SW'($signed(residual_i[i*RES_WIDTH +: RES_WIDTH]));
`ifdef MC_SAT_EN
      if (sum[SW-1]) begin
        sum_row[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
        clip_any = 1'b1;
      end else if (|sum[SW-2:PIXEL_WIDTH]) begin
        sum_row[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '1;
        clip_any = 1'b1;
      end else begin
        sum_row[i*PIXEL_WIDTH +: PIXEL_WIDTH] = sum[PIXEL_WIDTH-1:0];
      end
`else
      sum_row[i*PIXEL_WIDTH +: PIXEL_WIDTH] = sum[PIXEL_WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    recon_d       = recon_q;
    recon_valid_d = recon_valid_q;
    block_done_d  = 1'b0;
`ifdef MC_SAT_EN
    sat_d         = sat_q;
`endif

    // A new row entering in the same cycle as the old one leaves keeps valid high.
    if (res_hs) begin
      recon_d       = sum_row;
      recon_valid_d = 1'b1;
    end else if (out_hs) begin
      recon_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ref_hs) begin
`ifdef MC_SAT_EN
          sat_d = 1'b0;
`endif
          if (MB_SIZE == 1) begin
            state_d   = RECON;
            row_cnt_d = 4'd0;
          end else begin
            state_d   = LOAD_REF;
            row_cnt_d = 4'd1;
          end
        end
      end
      LOAD_REF: begin
        if (ref_hs) begin
          if (last_row) begin
            state_d   = RECON;
            row_cnt_d = 4'd0;
          end else begin
            row_cnt_d = row_cnt_q + 4'd1;
          end
        end
      end
      RECON: begin
        if (res_hs) begin
`ifdef MC_SAT_EN
          sat_d = sat_q | clip_any;
`endif
          if (last_row) begin
            state_d   = DRAIN;
            row_cnt_d = 4'd0;
          end else begin
            row_cnt_d = row_cnt_q + 4'd1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          state_d      = IDLE;
          block_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      row_cnt_q     <= 4'd0;
      recon_q       <= '0;
      recon_valid_q <= 1'b0;
      block_done_q  <= 1'b0;
`ifdef MC_SAT_EN
      sat_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      recon_q       <= recon_d;
      recon_valid_q <= recon_valid_d;
      block_done_q  <= block_done_d;
`ifdef MC_SAT_EN
      sat_q         <= sat_d;
`endif
    end
  end

  // Reference storage needs no reset; every row is rewritten before it is read.
  always_ff @(posedge clk_i) begin
    if (ref_hs) ref_buf_q[wr_idx] <= ref_frame_i;
  end

  assign recon_valid_o = recon_valid_q;
  assign recon_o       = recon_q;
  assign row_count_o   = row_cnt_q;
  assign block_done_o  = block_done_q;
`ifdef MC_SAT_EN
  assign sat_flag_o    = sat_q;
`else
  assign sat_flag_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_recon.sv
// Directed bench for mc_recon: vector tables plus hand-written backpressure, reset and back-to-back sequences.
module tb_mc_recon;
  localparam int MB = 4;
  localparam int PW = 8;
  localparam int RW = 9;
`ifdef MC_SAT_EN
  localparam logic        SAT_ON   = 1'b1;
  localparam logic [31:0] CLIP_ROW = 32'h008000FF;
`else
  localparam logic        SAT_ON   = 1'b0;
  localparam logic [31:0] CLIP_ROW = 32'h0080FE04;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ref_valid = 1'b0;
  logic        res_valid = 1'b0;
  logic        recon_ready = 1'b0;
  logic [31:0] ref_frame = '0;
  logic [35:0] residual = '0;
  logic        ref_ready, res_ready, recon_valid, block_done, sat_flag;
  logic [31:0] recon;
  logic [3:0]  row_count;

  always #5 clk = ~clk;

  mc_recon #(.MB_SIZE(MB), .PIXEL_WIDTH(PW), .RES_WIDTH(RW)) dut (
    .clk_i(clk), .reset_i(reset),
    .ref_valid_i(ref_valid), .ref_ready_o(ref_ready), .ref_frame_i(ref_frame),
    .res_valid_i(res_valid), .res_ready_o(res_ready), .residual_i(residual),
    .recon_valid_o(recon_valid), .recon_ready_i(recon_ready), .recon_o(recon),
    .row_count_o(row_count), .block_done_o(block_done), .sat_flag_o(sat_flag)
  );

  typedef struct packed {
    logic        rst;
    logic        refv;
    logic [31:0] refd;
    logic        resv;
    logic [35:0] resd;
    logic        rdy;
    logic        e_refr;
    logic        e_resr;
    logic        e_rv;
    logic        cr;
    logic [31:0] e_recon;
    logic [3:0]  e_rc;
    logic        e_bd;
    logic        e_sat;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mon_q[$];
  vec_t        t1[$];
  vec_t        t2[$];

  always @(posedge clk) if (!reset && recon_valid && recon_ready) mon_q.push_back(recon);

  function automatic logic [35:0] res4(input int a0, input int a1, input int a2, input int a3);
    return {a3[8:0], a2[8:0], a1[8:0], a0[8:0]};
  endfunction

  function automatic vec_t mk(input logic rst, input logic refv, input logic [31:0] refd,
                              input logic resv, input logic [35:0] resd, input logic rdy,
                              input logic e_refr, input logic e_resr, input logic e_rv,
                              input logic cr, input logic [31:0] e_recon, input logic [3:0] e_rc,
                              input logic e_bd, input logic e_sat);
    vec_t v;
    v.rst = rst; v.refv = refv; v.refd = refd; v.resv = resv; v.resd = resd; v.rdy = rdy;
    v.e_refr = e_refr; v.e_resr = e_resr; v.e_rv = e_rv; v.cr = cr; v.e_recon = e_recon;
    v.e_rc = e_rc; v.e_bd = e_bd; v.e_sat = e_sat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, check readies before the rising edge, check registers just after it.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    reset = v.rst; ref_valid = v.refv; ref_frame = v.refd;
    res_valid = v.resv; residual = v.resd; recon_ready = v.rdy;
    #1;
    chk({nm, ".ref_ready"}, {35'd0, ref_ready}, {35'd0, v.e_refr});
    chk({nm, ".res_ready"}, {35'd0, res_ready}, {35'd0, v.e_resr});
    @(posedge clk);
    #1;
    chk({nm, ".recon_valid"}, {35'd0, recon_valid}, {35'd0, v.e_rv});
    if (v.cr) chk({nm, ".recon"}, {4'd0, recon}, {4'd0, v.e_recon});
    chk({nm, ".row_count"}, {32'd0, row_count}, {32'd0, v.e_rc});
    chk({nm, ".block_done"}, {35'd0, block_done}, {35'd0, v.e_bd});
    chk({nm, ".sat_flag"}, {35'd0, sat_flag}, {35'd0, v.e_sat});
  endtask

  task automatic load_block(input logic [31:0] d, input string nm);
    for (int r = 0; r < MB; r++)
      step(mk(1'b0, 1'b1, d, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0,
              (r == MB-1) ? 4'd0 : 4'(r+1), 1'b0, 1'b0), $sformatf("%s.load%0d", nm, r));
  endtask

  task automatic chk_mon(input string nm, input int n, input logic [31:0] exp [8]);
    chk({nm, ".rows_out"}, 36'(mon_q.size()), 36'(n));
    for (int i = 0; i < n && i < mon_q.size(); i++)
      chk($sformatf("%s.row%0d", nm, i), {4'd0, mon_q[i]}, {4'd0, exp[i]});
  endtask

  localparam logic [31:0] R80 = 32'h80808080;
  localparam logic [31:0] R1  = 32'h10203040;
  localparam logic [31:0] RC  = 32'h008003FA;

  initial begin
    logic [35:0] p5, pz, pc0, pc1, pm1;
    logic [31:0] exp_rows [8];
    int          k;
    logic        erv;
    logic [3:0]  erc;

    p5  = res4(5, 5, 5, 5);
    pz  = res4(0, 0, 0, 0);
    pc0 = res4(1, -1, 0, 0);
    pc1 = res4(10, -5, 0, 0);
    pm1 = res4(-1, -1, -1, -1);

    // Basic block; res_valid during LOAD_REF and ref_valid during RECON/DRAIN must be ignored.
    t1.push_back(mk(1'b0,1'b1,R80,         1'b0,'0,1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd1,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,R80,         1'b1,p5,1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd2,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,R80,         1'b1,p5,1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd3,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,R80,         1'b0,'0,1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd0,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,32'h11111111,1'b1,p5,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h85858585,4'd1,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,32'h11111111,1'b1,p5,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h85858585,4'd2,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,32'h11111111,1'b1,p5,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h85858585,4'd3,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,32'h11111111,1'b1,p5,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h85858585,4'd0,1'b0,1'b0));
    t1.push_back(mk(1'b0,1'b1,32'h11111111,1'b0,'0,1'b1, 1'b0,1'b0, 1'b0,1'b1,32'h85858585,4'd0,1'b1,1'b0));
    t1.push_back(mk(1'b0,1'b0,'0,          1'b0,'0,1'b1, 1'b1,1'b0, 1'b0,1'b1,32'h85858585,4'd0,1'b0,1'b0));

    // Clip / wrap block: row 1 overflows lane 0 and underflows lane 1.
    t2.push_back(mk(1'b0,1'b1,R1,1'b0,'0, 1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd1,1'b0,1'b0));
    t2.push_back(mk(1'b0,1'b1,RC,1'b0,'0, 1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd2,1'b0,1'b0));
    t2.push_back(mk(1'b0,1'b1,R1,1'b0,'0, 1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd3,1'b0,1'b0));
    t2.push_back(mk(1'b0,1'b1,R1,1'b0,'0, 1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd0,1'b0,1'b0));
    t2.push_back(mk(1'b0,1'b0,'0,1'b1,pc0,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h10202F41,4'd1,1'b0,1'b0));
    t2.push_back(mk(1'b0,1'b0,'0,1'b1,pc1,1'b1, 1'b0,1'b1, 1'b1,1'b1,CLIP_ROW,    4'd2,1'b0,SAT_ON));
    t2.push_back(mk(1'b0,1'b0,'0,1'b1,pz, 1'b1, 1'b0,1'b1, 1'b1,1'b1,R1,          4'd3,1'b0,SAT_ON));
    t2.push_back(mk(1'b0,1'b0,'0,1'b1,pz, 1'b1, 1'b0,1'b1, 1'b1,1'b1,R1,          4'd0,1'b0,SAT_ON));
    t2.push_back(mk(1'b0,1'b0,'0,1'b0,'0, 1'b1, 1'b0,1'b0, 1'b0,1'b1,R1,          4'd0,1'b1,SAT_ON));
    t2.push_back(mk(1'b0,1'b0,'0,1'b0,'0, 1'b1, 1'b1,1'b0, 1'b0,1'b1,R1,          4'd0,1'b0,SAT_ON));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ref_ready",   {35'd0, ref_ready},   36'd1);
    chk("rst.res_ready",   {35'd0, res_ready},   36'd0);
    chk("rst.recon_valid", {35'd0, recon_valid}, 36'd0);
    chk("rst.recon",       {4'd0, recon},        36'd0);
    chk("rst.row_count",   {32'd0, row_count},   36'd0);
    chk("rst.block_done",  {35'd0, block_done},  36'd0);
    chk("rst.sat_flag",    {35'd0, sat_flag},    36'd0);

    for (int i = 0; i < t1.size(); i++) step(t1[i], $sformatf("basic[%0d]", i));
    for (int i = 0; i < t2.size(); i++) step(t2[i], $sformatf("clip[%0d]", i));

    // Backpressure: downstream stalls for 3 cycles after row 1; first load also clears sat_flag.
    mon_q.delete();
    load_block(R80, "bp");
    step(mk(1'b0,1'b0,'0,1'b1,res4(1,1,1,1),1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h81818181,4'd1,1'b0,1'b0), "bp.r0");
    step(mk(1'b0,1'b0,'0,1'b1,res4(2,2,2,2),1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h82828282,4'd2,1'b0,1'b0), "bp.r1");
    for (int s = 0; s < 3; s++)
      step(mk(1'b0,1'b0,'0,1'b1,res4(3,3,3,3),1'b0, 1'b0,1'b0, 1'b1,1'b1,32'h82828282,4'd2,1'b0,1'b0),
           $sformatf("bp.stall%0d", s));
    step(mk(1'b0,1'b0,'0,1'b1,res4(3,3,3,3),1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h83838383,4'd3,1'b0,1'b0), "bp.r2");
    step(mk(1'b0,1'b0,'0,1'b1,res4(4,4,4,4),1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h84848484,4'd0,1'b0,1'b0), "bp.r3");
    step(mk(1'b0,1'b0,'0,1'b0,'0,           1'b0, 1'b0,1'b0, 1'b1,1'b1,32'h84848484,4'd0,1'b0,1'b0), "bp.hold");
    step(mk(1'b0,1'b0,'0,1'b0,'0,           1'b1, 1'b0,1'b0, 1'b0,1'b1,32'h84848484,4'd0,1'b1,1'b0), "bp.drain");
    step(mk(1'b0,1'b0,'0,1'b0,'0,           1'b1, 1'b1,1'b0, 1'b0,1'b0,'0,          4'd0,1'b0,1'b0), "bp.idle");
    exp_rows = '{32'h81818181, 32'h82828282, 32'h83838383, 32'h84848484, '0, '0, '0, '0};
    chk_mon("bp", 4, exp_rows);

    // Reset mid-RECON with a row pending, then a fresh block.
    load_block(R80, "mr");
    step(mk(1'b0,1'b0,'0,1'b1,p5,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h85858585,4'd1,1'b0,1'b0), "mr.r0");
    step(mk(1'b0,1'b0,'0,1'b1,p5,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h85858585,4'd2,1'b0,1'b0), "mr.r1");
    step(mk(1'b1,1'b0,'0,1'b0,'0,1'b0, 1'b0,1'b0, 1'b0,1'b1,32'h0,       4'd0,1'b0,1'b0), "mr.reset");
    load_block(32'h01020304, "mr2");
    for (int r = 0; r < MB; r++)
      step(mk(1'b0,1'b0,'0,1'b1,p5,1'b1, 1'b0,1'b1, 1'b1,1'b1,32'h06070809,
              (r == MB-1) ? 4'd0 : 4'(r+1), 1'b0, 1'b0), $sformatf("mr2.res%0d", r));
    step(mk(1'b0,1'b0,'0,1'b0,'0,1'b1, 1'b0,1'b0, 1'b0,1'b1,32'h06070809,4'd0,1'b1,1'b0), "mr2.drain");

    // Back-to-back blocks with every valid and ready held high.
    mon_q.delete();
    for (int c = 0; c < 18; c++) begin
      k   = (c < 9) ? c : c - 9;
      erv = (k >= 4) && (k < 8);
      erc = (k < 3) ? 4'(k + 1) : (k == 3) ? 4'd0 : (k < 7) ? 4'(k - 3) : 4'd0;
      step(mk(1'b0, 1'b1, (c < 4) ? R80 : 32'h40404040, 1'b1, (c < 8) ? p5 : pm1, 1'b1,
              (k < 4), erv, erv, erv, (c < 9) ? 32'h85858585 : 32'h3F3F3F3F, erc,
              (k == 8), 1'b0), $sformatf("b2b[%0d]", c));
    end
    exp_rows = '{32'h85858585, 32'h85858585, 32'h85858585, 32'h85858585,
                 32'h3F3F3F3F, 32'h3F3F3F3F, 32'h3F3F3F3F, 32'h3F3F3F3F};
    chk_mon("b2b", 8, exp_rows);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
